// File: rtl/alu_seg_scan.sv
// Registered 4-function ALU with a valid/ready handshake, carry/zero flags, an
// accumulate mode, and a refresh scanner that multiplexes the result onto 7-seg digits.
module alu_seg_scan #(
  parameter int N       = 8,
  parameter int REFRESH = 4,
  localparam int DIGITS = N / 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      A,
  input  logic [N-1:0]      B,
  input  logic [1:0]        OPcode,
  input  logic              acc,
  input  logic              valid_in,
  output logic              ready,
  output logic              done,
  output logic [N-1:0]      result,
  output logic              carry,
  output logic              zero,
  input  logic              ENable,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an
);

  localparam int CW = (REFRESH > 1) ? $clog2(REFRESH) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {IDLE, CALC} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   a_q, a_d, b_q, b_d;
  logic [1:0]     op_q, op_d;
  logic [N-1:0]   result_q, result_d;
  logic           carry_q, carry_d, zero_q, zero_d, done_q, done_d;
  logic [CW-1:0]  cnt_q;
  logic [IW-1:0]  idx_q;

  logic [N:0]     wide;
  logic [N-1:0]   alu_res;
  logic           alu_c;

  // The extra top bit of the N+1-bit difference is exactly the borrow (A<B).
  always_comb begin
    wide    = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    case (op_q)
      2'b00: begin
        wide    = {1'b0, a_q} + {1'b0, b_q};
        alu_res = wide[N-1:0];
        alu_c   = wide[N];
      end
      2'b01: alu_res = a_q | b_q;
      2'b10: begin
        wide    = {1'b0, a_q} - {1'b0, b_q};
        alu_res = wide[N-1:0];
        alu_c   = wide[N];
      end
      default: alu_res = a_q ^ b_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_in) begin
          a_d     = acc ? result_q : A;
          b_d     = B;
          op_d    = OPcode;
          state_d = CALC;
        end
      end
      default: begin
        result_d = alu_res;
        carry_d  = alu_c;
        zero_d   = (alu_res == '0);
        done_d   = 1'b1;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
    end
  end

  // Scanner free-runs regardless of ENable so re-enabling resumes mid-scan.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else if (cnt_q == CW'(REFRESH - 1)) begin
      cnt_q <= '0;
      idx_q <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  logic [3:0] nibbles [DIGITS];
  logic [3:0] nib;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
      assign nibbles[gi] = result_q[4*gi +: 4];
    end
  endgenerate

  assign nib = nibbles[idx_q];

  logic [6:0] seg_dec;

  always_comb begin
    seg_dec = 7'b0000000;
    case (nib)
      4'h0: seg_dec = 7'b1111110;
      4'h1: seg_dec = 7'b0110000;
      4'h2: seg_dec = 7'b1101101;
      4'h3: seg_dec = 7'b1111001;
      4'h4: seg_dec = 7'b0110011;
      4'h5: seg_dec = 7'b1011011;
      4'h6: seg_dec = 7'b1011111;
      4'h7: seg_dec = 7'b1110000;
      4'h8: seg_dec = 7'b1111111;
      4'h9: seg_dec = 7'b1111011;
      4'hA: seg_dec = 7'b1110111;
      4'hB: seg_dec = 7'b0011111;
      4'hC: seg_dec = 7'b1001110;
      4'hD: seg_dec = 7'b0111101;
      4'hE: seg_dec = 7'b1001111;
      default: seg_dec = 7'b1000111;
    endcase
  end

  assign ready  = (state_q == IDLE);
  assign done   = done_q;
  assign result = result_q;
  assign carry  = carry_q;
  assign zero   = zero_q;
  assign seg    = ENable ? seg_dec : 7'b0000000;
  assign an     = ENable ? (DIGITS'(1) << idx_q) : '0;

endmodule

// File: tb/tb_alu_seg_scan.sv
// Directed-vector bench for alu_seg_scan (N=8, REFRESH=4): handshake timing,
// arithmetic and flags, accumulate, scanner sequencing, back-to-back and abort.
module tb_alu_seg_scan;

  logic       clk, rst;
  logic [7:0] A, B;
  logic [1:0] OPcode;
  logic       acc, valid_in, ready, done, carry, zero, ENable;
  logic [7:0] result;
  logic [6:0] seg;
  logic [1:0] an;

  int checks   = 0;
  int failures = 0;
  int n        = 0;

  alu_seg_scan #(.N(8), .REFRESH(4)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .OPcode(OPcode), .acc(acc),
    .valid_in(valid_in), .ready(ready), .done(done), .result(result),
    .carry(carry), .zero(zero), .ENable(ENable), .seg(seg), .an(an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] op, input logic ac);
    A = a; B = b; OPcode = op; acc = ac; valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    ENable = 1'b0; valid_in = 1'b0; A = '0; B = '0; OPcode = '0; acc = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0; n = 0;
    checks++; if (result !== 8'h00) begin failures++; $display("FAIL reset_result got=%h exp=00", result); end
    checks++; if (carry !== 1'b0) begin failures++; $display("FAIL reset_carry got=%b exp=0", carry); end
    checks++; if (zero !== 1'b0) begin failures++; $display("FAIL reset_zero got=%b exp=0", zero); end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (an !== 2'b00) begin failures++; $display("FAIL reset_an_off got=%b exp=00", an); end
    checks++; if (seg !== 7'b0000000) begin failures++; $display("FAIL reset_seg_off got=%b exp=0000000", seg); end
    ENable = 1'b1; #1;
    checks++; if (an !== 2'b01) begin failures++; $display("FAIL reset_an_on got=%b exp=01", an); end
    checks++; if (seg !== 7'b1111110) begin failures++; $display("FAIL reset_seg_on got=%b exp=1111110", seg); end
    ENable = 1'b0;
    $display("reset: result=%h ready=%b an=%b", result, ready, an);
  endtask

  task automatic test_add;
    A = 8'hF0; B = 8'h25; OPcode = 2'b00; acc = 1'b0; valid_in = 1'b1;
    tick();
    valid_in = 1'b0; A = 8'h00; B = 8'h00;
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL add_ready_calc got=%b exp=0", ready); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL add_done_early got=%b exp=0", done); end
    tick();
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL add_done got=%b exp=1", done); end
    checks++; if (result !== 8'h15) begin failures++; $display("FAIL add_result got=%h exp=15", result); end
    checks++; if (carry !== 1'b1) begin failures++; $display("FAIL add_carry got=%b exp=1", carry); end
    checks++; if (zero !== 1'b0) begin failures++; $display("FAIL add_zero got=%b exp=0", zero); end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL add_ready_back got=%b exp=1", ready); end
    tick();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL add_done_pulse got=%b exp=0", done); end
    $display("add: F0+25 -> result=%h carry=%b zero=%b", result, carry, zero);
  endtask

  task automatic test_sub;
    do_op(8'h10, 8'h10, 2'b10, 1'b0);
    checks++; if (result !== 8'h00) begin failures++; $display("FAIL sub_eq_result got=%h exp=00", result); end
    checks++; if (zero !== 1'b1) begin failures++; $display("FAIL sub_eq_zero got=%b exp=1", zero); end
    checks++; if (carry !== 1'b0) begin failures++; $display("FAIL sub_eq_carry got=%b exp=0", carry); end
    $display("sub: 10-10 -> result=%h carry=%b zero=%b", result, carry, zero);
    do_op(8'h03, 8'h05, 2'b10, 1'b0);
    checks++; if (result !== 8'hFE) begin failures++; $display("FAIL sub_borrow_result got=%h exp=FE", result); end
    checks++; if (carry !== 1'b1) begin failures++; $display("FAIL sub_borrow_carry got=%b exp=1", carry); end
    checks++; if (zero !== 1'b0) begin failures++; $display("FAIL sub_borrow_zero got=%b exp=0", zero); end
    $display("sub: 03-05 -> result=%h carry=%b zero=%b", result, carry, zero);
  endtask

  task automatic test_accumulate;
    do_op(8'hF0, 8'h25, 2'b00, 1'b0);
    do_op(8'hFF, 8'h15, 2'b11, 1'b1);
    checks++; if (result !== 8'h00) begin failures++; $display("FAIL acc_xor_result got=%h exp=00", result); end
    checks++; if (zero !== 1'b1) begin failures++; $display("FAIL acc_xor_zero got=%b exp=1", zero); end
    checks++; if (carry !== 1'b0) begin failures++; $display("FAIL acc_xor_carry got=%b exp=0", carry); end
    $display("acc: 15^15 -> result=%h zero=%b", result, zero);
    do_op(8'hFF, 8'h0A, 2'b01, 1'b1);
    checks++; if (result !== 8'h0A) begin failures++; $display("FAIL acc_or_result got=%h exp=0A", result); end
    checks++; if (zero !== 1'b0) begin failures++; $display("FAIL acc_or_zero got=%b exp=0", zero); end
    $display("acc: 00|0A -> result=%h zero=%b", result, zero);
  endtask

  task automatic test_scan;
    int idx;
    logic [1:0] exp_an;
    logic [6:0] exp_seg;
    ENable = 1'b1;
    rst = 1'b1; tick(); rst = 1'b0; n = 0;
    do_op(8'h30, 8'h0A, 2'b00, 1'b0);
    checks++; if (result !== 8'h3A) begin failures++; $display("FAIL scan_result got=%h exp=3A", result); end
    for (int i = 0; i < 16; i++) begin
      idx = (n / 4) % 2;
      exp_an  = (idx == 0) ? 2'b01 : 2'b10;
      exp_seg = (idx == 0) ? 7'b1110111 : 7'b1111001;
      checks++; if (an !== exp_an || seg !== exp_seg) begin failures++; $display("FAIL scan_on cyc=%0d got an=%b seg=%b exp an=%b seg=%b", n, an, seg, exp_an, exp_seg); end
      $display("scan: cyc=%0d an=%b seg=%b", n, an, seg);
      tick();
    end
    ENable = 1'b0; #1;
    for (int i = 0; i < 6; i++) begin
      checks++; if (an !== 2'b00 || seg !== 7'b0000000) begin failures++; $display("FAIL scan_off cyc=%0d got an=%b seg=%b exp an=00 seg=0000000", n, an, seg); end
      tick();
    end
    ENable = 1'b1; #1;
    for (int i = 0; i < 8; i++) begin
      idx = (n / 4) % 2;
      exp_an  = (idx == 0) ? 2'b01 : 2'b10;
      exp_seg = (idx == 0) ? 7'b1110111 : 7'b1111001;
      checks++; if (an !== exp_an || seg !== exp_seg) begin failures++; $display("FAIL scan_resume cyc=%0d got an=%b seg=%b exp an=%b seg=%b", n, an, seg, exp_an, exp_seg); end
      $display("scan: resume cyc=%0d an=%b seg=%b", n, an, seg);
      tick();
    end
    ENable = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [7:0] va [3] = '{8'h01, 8'h0C, 8'hFF};
    logic [7:0] vb [3] = '{8'h02, 8'h03, 8'h0F};
    logic [1:0] vo [3] = '{2'b00, 2'b01, 2'b11};
    logic [7:0] ve [3] = '{8'h03, 8'h0F, 8'hF0};
    int dones = 0;
    valid_in = 1'b1; acc = 1'b0;
    for (int i = 0; i < 3; i++) begin
      A = va[i]; B = vb[i]; OPcode = vo[i];
      tick();
      checks++; if (ready !== 1'b0) begin failures++; $display("FAIL b2b_accept op=%0d got ready=%b exp=0", i, ready); end
      A = 8'h55; B = 8'hAA; OPcode = 2'b10;
      tick();
      if (done === 1'b1) dones++;
      checks++; if (result !== ve[i] || ready !== 1'b1) begin failures++; $display("FAIL b2b_result op=%0d got=%h ready=%b exp=%h ready=1", i, result, ready, ve[i]); end
      $display("b2b: op=%0d result=%h done=%b", i, result, done);
    end
    valid_in = 1'b0;
    checks++; if (dones !== 3) begin failures++; $display("FAIL b2b_dones got=%0d exp=3", dones); end
    tick();
    checks++; if (done !== 1'b0 || ready !== 1'b1) begin failures++; $display("FAIL b2b_idle got done=%b ready=%b exp done=0 ready=1", done, ready); end
  endtask

  task automatic test_abort;
    int dones = 0;
    A = 8'h11; B = 8'h22; OPcode = 2'b00; acc = 1'b0; valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL abort_in_calc got ready=%b exp=0", ready); end
    rst = 1'b1; #1;
    checks++; if (result !== 8'h00) begin failures++; $display("FAIL abort_result got=%h exp=00", result); end
    checks++; if (ready !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL abort_ctrl got ready=%b done=%b exp ready=1 done=0", ready, done); end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (done === 1'b1) dones++;
      tick();
    end
    checks++; if (dones !== 0 || result !== 8'h00) begin failures++; $display("FAIL abort_after got dones=%0d result=%h exp dones=0 result=00", dones, result); end
    $display("abort: result=%h ready=%b done_count=%0d", result, ready, dones);
  endtask

  initial begin
    rst = 1'b1; ENable = 1'b0; valid_in = 1'b0;
    A = '0; B = '0; OPcode = '0; acc = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_accumulate();
    test_scan();
    test_back_to_back();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
